// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the iterative ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SRL  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_SRA  = 3'b101,
    OP_SLL  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_e;

endpackage

// File: rtl/adder_n.sv
// Parametrised ripple adder with carry in/out.
module adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_iter.sv
// Registered ALU with valid/ready handshake; shifts step one bit per cycle,
// MUL is an iterative unsigned shift-add.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam int MSB     = WIDTH - 1;

  alu_state_e state, state_next;

  alu_op_e              op_in, op_q;
  logic [SHAMT_W-1:0]   amt_in;
  logic                 accept;
  logic                 is_shift_in;

  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     work;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   prod;

  logic [WIDTH-1:0]     add_a, add_b, add_sum;
  logic                 add_cin, add_cout;

  logic [WIDTH-1:0]     sh_next;
  logic                 sh_bit;
  logic [2*WIDTH-1:0]   p_next;

  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v, load;

  assign op_in       = alu_op_e'(ctrl);
  assign amt_in      = rs2[SHAMT_W-1:0];
  assign accept      = in_valid && in_ready;
  assign is_shift_in = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);

  // One adder serves ADD/SUB at accept and the MUL accumulate while busy.
  adder_n #(.WIDTH(WIDTH)) u_add (
    .cin  (add_cin),
    .A    (add_a),
    .B    (add_b),
    .S    (add_sum),
    .Cout (add_cout)
  );

  // Adder operand selection
  always_comb begin
    add_a   = rs1;
    add_b   = rs2;
    add_cin = 1'b0;
    if (state == BUSY) begin
      add_a = prod[2*WIDTH-1:WIDTH];
      add_b = prod[0] ? mcand : '0;
    end else if (op_in == OP_SUB) begin
      add_b   = ~rs2;
      add_cin = 1'b1;
    end
  end

  // Single shift step and single multiply step on the latched operands
  always_comb begin
    sh_next = work;
    sh_bit  = 1'b0;
    case (op_q)
      OP_SLL:  {sh_bit, sh_next} = {work, 1'b0};
      OP_SRL:  {sh_next, sh_bit} = {1'b0, work};
      OP_SRA:  {sh_next, sh_bit} = {work[MSB], work};
      default: ;
    endcase
    // Product register holds {partial high, remaining multiplier}; shift right
    // each step with the adder carry entering at the top.
    p_next = {add_cout, add_sum, prod[WIDTH-1:1]};
  end

  // Result and flags to register this cycle, if any
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    load  = 1'b0;
    if (state == IDLE && accept) begin
      case (op_in)
        OP_ADD, OP_SUB: begin
          res   = add_sum;
          res_c = add_cout;
          res_v = (rs1[MSB] == add_b[MSB]) && (add_sum[MSB] != rs1[MSB]);
          load  = 1'b1;
        end
        OP_NOR: begin
          res  = ~(rs1 | rs2);
          load = 1'b1;
        end
        OP_NAND: begin
          res  = ~(rs1 & rs2);
          load = 1'b1;
        end
        OP_SLL, OP_SRL, OP_SRA: begin
          if (amt_in == '0) begin
            res  = rs1;
            load = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (state == BUSY && cnt == CNT_W'(1)) begin
      load = 1'b1;
      if (op_q == OP_MUL) begin
        res   = p_next[WIDTH-1:0];
        res_c = |p_next[2*WIDTH-1:WIDTH];
      end else begin
        res   = sh_next;
        res_c = sh_bit;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op_in == OP_MUL || (is_shift_in && amt_in != '0)) state_next = BUSY;
          else                                                   state_next = DONE;
        end
      end
      BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM handshake outputs
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: operand latching, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      cnt      <= '0;
      work     <= '0;
      mcand    <= '0;
      prod     <= '0;
      op_q     <= OP_ADD;
    end else begin
      if (load) begin
        out      <= res;
        carry    <= res_c;
        overflow <= res_v;
        zero     <= (res == '0);
        negative <= res[MSB];
      end
      if (state == IDLE && accept) begin
        op_q  <= op_in;
        work  <= rs1;
        mcand <= rs1;
        prod  <= {{WIDTH{1'b0}}, rs2};
        cnt   <= (op_in == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, amt_in};
      end else if (state == BUSY) begin
        work <= sh_next;
        prod <= p_next;
        cnt  <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed vector bench for alu_iter (WIDTH=8).
module tb_alu_iter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] rs1, rs2, out;
  logic [2:0] ctrl;
  logic       carry, overflow, zero, negative;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  typedef struct {
    alu_op_e     op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  y;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    int unsigned busy;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int unsigned busy;
    bit          rdy_low;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    ctrl     = v.op;
    rs1      = v.a;
    rs2      = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    rs1      = 8'($urandom);
    rs2      = 8'($urandom);
    ctrl     = 3'($urandom);
    busy     = 0;
    rdy_low  = 1'b1;
    while (!out_valid && busy < 40) begin
      if (in_ready) rdy_low = 1'b0;
      busy++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, busy, v.busy);
    check({tag, " in_ready low while busy"}, 32'(rdy_low), 32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " in_ready done"}, 32'(in_ready), 32'd0);
    check({tag, " out"}, 32'(out), 32'(v.y));
    check({tag, " carry"}, 32'(carry), 32'(v.c));
    check({tag, " overflow"}, 32'(overflow), 32'(v.v));
    check({tag, " zero"}, 32'(zero), 32'(v.z));
    check({tag, " negative"}, 32'(negative), 32'(v.n));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t w;

    //          op       a      b      y      c     v     z     n     busy
    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[1]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[2]  = '{OP_SUB,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[3]  = '{OP_SLL,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[4]  = '{OP_SRA,  8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 7};
    vecs[5]  = '{OP_SRL,  8'h01, 8'h09, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{OP_MUL,  8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[7]  = '{OP_MUL,  8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    vecs[8]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[9]  = '{OP_NOR,  8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[10] = '{OP_NAND, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[11] = '{OP_SRL,  8'h80, 8'h08, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[12] = '{OP_SRA,  8'h85, 8'h0B, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    vecs[13] = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{OP_ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[15] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0; ctrl = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out", 32'(out), 32'd0);
    check("reset flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int unsigned i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: DONE holds result while out_ready is low; in_valid ignored.
    @(negedge clk);
    in_valid = 1'b1; ctrl = OP_ADD; rs1 = 8'h12; rs2 = 8'h34;
    @(negedge clk);
    ctrl = OP_SUB; rs1 = 8'h01; rs2 = 8'h02;
    check("bp out_valid", 32'(out_valid), 32'd1);
    for (int unsigned k = 0; k < 5; k++) begin
      check("bp out stable", 32'(out), 32'h46);
      check("bp flags stable", {28'd0, carry, overflow, zero, negative}, 32'd0);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid held", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);

    // Reset during the 4th BUSY cycle of a MUL.
    @(negedge clk);
    in_valid = 1'b1; ctrl = OP_MUL; rs1 = 8'h0F; rs2 = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midmul still busy", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midmul rst out_valid", 32'(out_valid), 32'd0);
    check("midmul rst out", 32'(out), 32'd0);
    check("midmul rst flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
    check("midmul rst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midmul after in_ready", 32'(in_ready), 32'd1);
    check("midmul after out_valid", 32'(out_valid), 32'd0);

    w = '{OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    run_op("post-abort add", w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
